svm_ovo_scheduler: RTL and testbench

SVM_OVO_SCHEDULER -- requirements
Module: svm_ovo_scheduler

---
 rtl/svm_sched_pkg.sv | 18 +
 rtl/svm_vote_argmax.sv | 84 ++++++++
 rtl/svm_ovo_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_svm_ovo_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_sched_pkg.sv
// Shared definitions for the one-vs-one SVM vote scheduler.
//   sched_state_e : scheduler FSM state encoding (also exported on dbg_state)
//   pair_count()  : number of pairwise classifiers for a given class count
package svm_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

    function automatic int pair_count(input int n_classes);
        return (n_classes * (n_classes - 1)) / 2;
    endfunction

endpackage

// File: rtl/svm_vote_argmax.sv
// Sequential argmax over the per-class vote counters, one class per cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a scan from class 0 (ignored while busy)
//   votes      : packed vote counters, entry c belongs to class c
//   busy       : a scan is in progress
//   last       : this cycle examines the final class; win is the final result
//   win        : running winner including the class examined this cycle
// A class only replaces the current best when strictly greater, so ties
// resolve to the lowest index.
module svm_vote_argmax
    import svm_sched_pkg::*;
#(
    parameter int N_CLASSES  = 7,
    parameter int CLASS_BITS = 3,
    parameter int VOTE_W     = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_CLASSES-1:0][VOTE_W-1:0]     votes,
    output logic                                 busy,
    output logic                                 last,
    output logic [CLASS_BITS-1:0]                win
);

    logic                  busy_q, busy_d;
    logic [CLASS_BITS-1:0] idx_q, idx_d;
    logic [VOTE_W-1:0]     best_cnt_q, best_cnt_d;
    logic [CLASS_BITS-1:0] best_idx_q, best_idx_d;
    logic [VOTE_W-1:0]     cur_votes;
    logic                  greater;

    always_comb begin
        cur_votes = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (idx_q == CLASS_BITS'(c)) begin
                cur_votes = votes[c];
            end
        end
        greater = (cur_votes > best_cnt_q);
        win     = greater ? idx_q : best_idx_q;
        last    = busy_q && (idx_q == CLASS_BITS'(N_CLASSES - 1));
        busy    = busy_q;
    end

    always_comb begin
        busy_d     = busy_q;
        idx_d      = idx_q;
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        if (start && !busy_q) begin
            busy_d     = 1'b1;
            idx_d      = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
        end else if (busy_q) begin
            if (greater) begin
                best_cnt_d = cur_votes;
                best_idx_d = idx_q;
            end
            if (last) begin
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            idx_q      <= '0;
            best_cnt_q <= '0;
            best_idx_q <= '0;
        end else begin
            busy_q     <= busy_d;
            idx_q      <= idx_d;
            best_cnt_q <= best_cnt_d;
            best_idx_q <= best_idx_d;
        end
    end

endmodule

// File: rtl/svm_ovo_scheduler.sv
// One-vs-one SVM scheduler: walks every class pair (a<b) in lexicographic
// order over a shared pairwise datapath, tallies votes, then picks the class
// with the most votes (lowest index on ties).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : sample handshake
//   pair_start         : one-cycle launch of a pairwise evaluation
//   pair_a, pair_b     : pair under evaluation, stable from launch to pair_done
//   pair_done/pair_sign: datapath result (sign 1 = pair_a wins)
//   ready, w_class     : one-cycle result pulse; w_class holds until next result
//   cycles             : accept-to-ready cycle count (only with
//                        SVM_SCHED_CYCLE_CNT_EN defined)
//   dbg_state          : current FSM state
// Handshake: a sample is accepted on a rising edge where in_valid and
// in_ready are both 1; in_ready is 1 only in IDLE, so in_valid is a don't-care
// while a sample is in flight and never needs to be held after acceptance.
module svm_ovo_scheduler
    import svm_sched_pkg::*;
#(
    parameter int N_CLASSES  = 7,
    parameter int CLASS_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  pair_start,
    output logic [CLASS_BITS-1:0] pair_a,
    output logic [CLASS_BITS-1:0] pair_b,
    input  logic                  pair_done,
    input  logic                  pair_sign,
    output logic                  ready,
    output logic [CLASS_BITS-1:0] w_class,
`ifdef SVM_SCHED_CYCLE_CNT_EN
    output logic [15:0]           cycles,
`endif
    output sched_state_e          dbg_state
);

    localparam int VOTE_W = $clog2(N_CLASSES);
    localparam int PAIRS  = pair_count(N_CLASSES);
    localparam int PCNT_W = $clog2(PAIRS);
    localparam logic [CLASS_BITS-1:0] LAST_B = CLASS_BITS'(N_CLASSES - 1);

    sched_state_e                     state_q, state_d;
    logic [CLASS_BITS-1:0]            pair_a_q, pair_a_d;
    logic [CLASS_BITS-1:0]            pair_b_q, pair_b_d;
    logic [PCNT_W-1:0]                pair_num_q, pair_num_d;
    logic [N_CLASSES-1:0][VOTE_W-1:0] votes_q, votes_d;
    logic [CLASS_BITS-1:0]            w_class_q, w_class_d;
    logic [CLASS_BITS-1:0]            winner;

    logic                  scan_start;
    logic                  scan_busy;
    logic                  scan_last;
    logic [CLASS_BITS-1:0] scan_win;

    svm_vote_argmax #(
        .N_CLASSES  (N_CLASSES),
        .CLASS_BITS (CLASS_BITS),
        .VOTE_W     (VOTE_W)
    ) u_argmax (
        .clk   (clk),
        .rst   (rst),
        .start (scan_start),
        .votes (votes_q),
        .busy  (scan_busy),
        .last  (scan_last),
        .win   (scan_win)
    );

    always_comb begin
        state_d    = state_q;
        pair_a_d   = pair_a_q;
        pair_b_d   = pair_b_q;
        pair_num_d = pair_num_q;
        votes_d    = votes_q;
        w_class_d  = w_class_q;
        scan_start = 1'b0;
        winner     = pair_sign ? pair_a_q : pair_b_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    votes_d    = '0;
                    pair_a_d   = '0;
                    pair_b_d   = CLASS_BITS'(1);
                    pair_num_d = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pair_done) begin
                    for (int c = 0; c < N_CLASSES; c++) begin
                        if (winner == CLASS_BITS'(c)) begin
                            votes_d[c] = votes_q[c] + 1'b1;
                        end
                    end
                    // Pair counter reaching P-1 is the (N-2, N-1) pair.
                    if (pair_num_q == PCNT_W'(PAIRS - 1)) begin
                        state_d = ST_DECIDE;
                    end else begin
                        pair_num_d = pair_num_q + 1'b1;
                        if (pair_b_q == LAST_B) begin
                            pair_a_d = pair_a_q + 1'b1;
                            pair_b_d = pair_a_q + 2'd2;
                        end else begin
                            pair_b_d = pair_b_q + 1'b1;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DECIDE: begin
                // First DECIDE cycle arms the scanner; then one class per cycle.
                scan_start = !scan_busy;
                if (scan_last) begin
                    w_class_d = scan_win;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pair_a_q   <= '0;
            pair_b_q   <= CLASS_BITS'(1);
            pair_num_q <= '0;
            votes_q    <= '0;
            w_class_q  <= '0;
        end else begin
            state_q    <= state_d;
            pair_a_q   <= pair_a_d;
            pair_b_q   <= pair_b_d;
            pair_num_q <= pair_num_d;
            votes_q    <= votes_d;
            w_class_q  <= w_class_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign pair_start = (state_q == ST_ISSUE);
    assign ready      = (state_q == ST_DONE);
    assign pair_a     = pair_a_q;
    assign pair_b     = pair_b_q;
    assign w_class    = w_class_q;
    assign dbg_state  = state_q;

`ifdef SVM_SCHED_CYCLE_CNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] cycles_q, cycles_d;

    // cyc_cnt_q reads 1 in the first cycle after the accept edge; the value
    // latched into the DONE cycle therefore spans handshake cycle to ready.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        cycles_d  = cycles_q;
        if (state_q == ST_IDLE) begin
            if (in_valid) begin
                cyc_cnt_d = 16'd1;
            end
        end else if (cyc_cnt_q != 16'hFFFF) begin
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
        if (state_q == ST_DECIDE && scan_last) begin
            cycles_d = (cyc_cnt_q == 16'hFFFF) ? 16'hFFFF : cyc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            cycles_q  <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            cycles_q  <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_svm_ovo_scheduler.sv
// Testbench for svm_ovo_scheduler (N_CLASSES=7): table of full-sample runs
// with hand-computed winners and latencies, plus reset, abort and
// held-in_valid/spurious-pair_done sequences. Build with
// SVM_SCHED_CYCLE_CNT_EN defined to also check the cycles port.
module tb_svm_ovo_scheduler;
    import svm_sched_pkg::*;

    localparam int N  = 7;
    localparam int CB = 3;

    localparam int M_ALL1   = 0;  // pair_a always wins
    localparam int M_ALL0   = 1;  // pair_b always wins
    localparam int M_TIE    = 2;  // class2=5, class4=5
    localparam int M_PARITY = 3;  // a wins iff a+b odd: all classes 3 votes
    localparam int M_CLASS3 = 4;  // class 3 wins all its pairs

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid;
    logic          in_ready;
    logic          pair_start;
    logic [CB-1:0] pair_a;
    logic [CB-1:0] pair_b;
    logic          pair_done;
    logic          pair_sign;
    logic          ready;
    logic [CB-1:0] w_class;
    sched_state_e  dbg_state;
`ifdef SVM_SCHED_CYCLE_CNT_EN
    logic [15:0]   cycles;
`endif

    svm_ovo_scheduler #(.N_CLASSES(N), .CLASS_BITS(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pair_start (pair_start),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .pair_done  (pair_done),
        .pair_sign  (pair_sign),
        .ready      (ready),
        .w_class    (w_class),
`ifdef SVM_SCHED_CYCLE_CNT_EN
        .cycles     (cycles),
`endif
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sign_for(input int mode, input logic [CB-1:0] a, input logic [CB-1:0] b);
        case (mode)
            M_ALL1:   return 1'b1;
            M_ALL0:   return 1'b0;
            M_TIE: begin
                if (a == 3'd2 && b == 3'd4) return 1'b0;
                if (a == 3'd4 && b == 3'd6) return 1'b0;
                if (a == 3'd2 || a == 3'd4) return 1'b1;
                if (b == 3'd2 || b == 3'd4) return 1'b0;
                return 1'b1;
            end
            M_PARITY: return a[0] ^ b[0];
            M_CLASS3: return (b == 3'd3) ? 1'b0 : 1'b1;
            default:  return 1'b1;
        endcase
    endfunction

    // Drives one sample from a negedge and acts as the datapath with latency
    // lat. Pair order is scored against an expected queue built from nested
    // a<b loops. abort_at >= 0 pulses rst in the WAIT of that pair index.
    task automatic run_sample(input int mode, input int lat, input bit hold,
                              input bit spurious, input int abort_at,
                              output int n_pairs, output int order_err,
                              output int latency, output logic [CB-1:0] w,
                              output int n_ready, output int ir_hi);
        logic [2*CB-1:0] exp_q[$];
        logic [2*CB-1:0] e;
        logic [CB-1:0]   pa, pb;
        int              cnt_down, h, post_abort;
        bit              fin, aborted;

        n_pairs = 0; order_err = 0; latency = -1; w = '0; n_ready = 0; ir_hi = 0;
        pa = '0; pb = '0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                exp_q.push_back({CB'(a), CB'(b)});

        check("accept_in_ready", in_ready, 1);
        in_valid = 1'b1;
        h = cyc;
        cnt_down = -1; fin = 0; aborted = 0; post_abort = 0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            if (rst) rst = 1'b0;
            pair_done = 1'b0;
            pair_sign = 1'b0;
            if (in_ready && !aborted) ir_hi++;
            if (ready) begin
                n_ready++;
                latency = cyc - h;
                w = w_class;
                in_valid = 1'b0;
                if (!aborted) fin = 1;
            end
            if (cnt_down > 0) cnt_down--;
            if (cnt_down == 0) begin
                pair_done = 1'b1;
                pair_sign = sign_for(mode, pa, pb);
                cnt_down = -1;
            end
            if (pair_start) begin
                n_pairs++;
                pa = pair_a;
                pb = pair_b;
                if (exp_q.size() == 0) begin
                    order_err++;
                end else begin
                    e = exp_q.pop_front();
                    if ({pa, pb} !== e) order_err++;
                end
                cnt_down = lat;
                if (spurious) begin
                    pair_done = 1'b1;
                    pair_sign = 1'b0;
                end
            end
            if (spurious && dbg_state == ST_DECIDE) begin
                pair_done = 1'b1;
                pair_sign = 1'b0;
            end
            if (abort_at >= 0 && !aborted && n_pairs == abort_at + 1 && dbg_state == ST_WAIT) begin
                rst = 1'b1;
                aborted = 1;
            end
            if (aborted) begin
                post_abort++;
                if (post_abort > 40) fin = 1;
            end
        end
        check("run_terminated", fin, 1);
        pair_done = 1'b0;
        in_valid = 1'b0;
    endtask

    typedef struct {
        int            mode;
        int            lat;
        logic [CB-1:0] exp_w;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int            np, oe, lt, nr, ih, sp;
        logic [CB-1:0] wv;

        rst = 1'b1; in_valid = 1'b0; pair_done = 1'b0; pair_sign = 1'b0;

        // latency = 21*(1+L) + 7 + 2
        vecs[0] = '{M_ALL1,   3, 3'd0, 93};
        vecs[1] = '{M_ALL0,   3, 3'd6, 93};
        vecs[2] = '{M_TIE,    3, 3'd2, 93};
        vecs[3] = '{M_ALL1,   1, 3'd0, 51};
        vecs[4] = '{M_PARITY, 2, 3'd0, 72};
        vecs[5] = '{M_CLASS3, 4, 3'd3, 114};

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_ready", ready, 0);
        check("rst_w_class", w_class, 0);
        check("rst_pair_start", pair_start, 0);
        check("rst_pair_ab", {pair_a, pair_b}, {3'd0, 3'd1});
        check("rst_state", dbg_state, ST_IDLE);
`ifdef SVM_SCHED_CYCLE_CNT_EN
        check("rst_cycles", cycles, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // table-driven full samples
        for (int i = 0; i < 6; i++) begin
            run_sample(vecs[i].mode, vecs[i].lat, 1'b0, 1'b0, -1, np, oe, lt, wv, nr, ih);
            check($sformatf("v%0d_pairs", i), np, 21);
            check($sformatf("v%0d_order", i), oe, 0);
            check($sformatf("v%0d_ready_cnt", i), nr, 1);
            check($sformatf("v%0d_latency", i), lt, vecs[i].exp_lat);
            check($sformatf("v%0d_w_class", i), wv, vecs[i].exp_w);
            check($sformatf("v%0d_in_ready_busy", i), ih, 0);
`ifdef SVM_SCHED_CYCLE_CNT_EN
            check($sformatf("v%0d_cycles", i), cycles, vecs[i].exp_lat);
`endif
            @(negedge clk);
            check($sformatf("v%0d_ready_pulse", i), ready, 0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_w_hold", i), w_class, vecs[i].exp_w);
        end

        // reset in WAIT of pair 10 aborts the sample
        run_sample(M_ALL1, 3, 1'b0, 1'b0, 10, np, oe, lt, wv, nr, ih);
        check("abort_no_ready", nr, 0);
        check("abort_pairs", np, 11);
        check("abort_order", oe, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_w_cleared", w_class, 0);
        check("abort_state", dbg_state, ST_IDLE);

        // next sample starts from (0,1) with fresh votes
        run_sample(M_TIE, 3, 1'b0, 1'b0, -1, np, oe, lt, wv, nr, ih);
        check("post_abort_pairs", np, 21);
        check("post_abort_order", oe, 0);
        check("post_abort_latency", lt, 93);
        check("post_abort_w_class", wv, 2);
        @(negedge clk);

        // in_valid held high, spurious pair_done in ISSUE/DECIDE
        run_sample(M_ALL1, 3, 1'b1, 1'b1, -1, np, oe, lt, wv, nr, ih);
        check("hold_pairs", np, 21);
        check("hold_order", oe, 0);
        check("hold_ready_cnt", nr, 1);
        check("hold_in_ready_busy", ih, 0);
        check("hold_latency", lt, 93);
        check("hold_w_class", wv, 0);
`ifdef SVM_SCHED_CYCLE_CNT_EN
        check("hold_cycles", cycles, 93);
`endif
        sp = 0;
        repeat (5) begin
            @(negedge clk);
            if (pair_start) sp++;
        end
        check("hold_no_reaccept", sp, 0);
        check("hold_idle_state", dbg_state, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
